// File: rtl/remap_cache_fill.sv
// remap_cache_fill: buffers DRAM fill beats and writes them into remap-cache lines in ring order.
// Define REMAP_FILL_PERF_EN to add the saturating stall counters o_stall_full / o_stall_fifo.
module remap_cache_fill #(
  parameter  int LBW     = 5,
  parameter  int DBW     = 8,
  parameter  int VSIZE   = 4,
  parameter  int N_ICFG  = 3,
  parameter  int FDEPTH  = 2,
  localparam int HBW     = LBW - $clog2(VSIZE),
  localparam int NDATA   = 1 << HBW,
  localparam int ICFG_BW = $clog2(N_ICFG + 1),
  localparam int FPW     = $clog2(FDEPTH)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          fill_rdy,
  output logic                          fill_ack,
  input  logic [ICFG_BW-1:0]            i_fill_id,
  input  logic [VSIZE-1:0][DBW-1:0]     i_fill_data,
  output logic                          wad_dval,
  output logic [HBW-1:0]                o_whiaddr,
  output logic [VSIZE-1:0][DBW-1:0]     o_wdata,
  output logic [ICFG_BW-1:0]            o_wid,
  input  logic                          free_dval,
  input  logic [ICFG_BW-1:0]            i_free_id,
  output logic [HBW:0]                  o_occ,
  output logic                          o_err
`ifdef REMAP_FILL_PERF_EN
  ,
  output logic [31:0]                   o_stall_full,
  output logic [31:0]                   o_stall_fifo
`endif
);

  localparam logic [HBW:0] OCC_FULL  = (HBW + 1)'(NDATA);
  localparam logic [FPW:0] FIFO_FULL = (FPW + 1)'(FDEPTH);

  // Storage: fill FIFO and the shadow id RAM (one id per cache line).
  logic [VSIZE-1:0][DBW-1:0] fifo_data_q [FDEPTH];
  logic [ICFG_BW-1:0]        fifo_id_q   [FDEPTH];
  logic [ICFG_BW-1:0]        id_ram_q    [NDATA];

  logic [FPW-1:0]            fifo_wr_q, fifo_wr_d;
  logic [FPW-1:0]            fifo_rd_q, fifo_rd_d;
  logic [FPW:0]              fifo_cnt_q, fifo_cnt_d;
  logic                      ack_q, ack_d;
  logic [HBW-1:0]            wptr_q, wptr_d;
  logic [HBW-1:0]            rptr_q, rptr_d;
  logic [HBW:0]              occ_q, occ_d;
  logic                      err_q, err_d;
  logic                      wad_q, wad_d;
  logic [HBW-1:0]            whiaddr_q, whiaddr_d;
  logic [VSIZE-1:0][DBW-1:0] wdata_q, wdata_d;
  logic [ICFG_BW-1:0]        wid_q, wid_d;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic                      free_ok;
  logic [ICFG_BW-1:0]        head_id;
  logic [ICFG_BW-1:0]        exp_free_id;

  always_comb begin
    fifo_full   = (fifo_cnt_q == FIFO_FULL);
    fifo_empty  = (fifo_cnt_q == '0);
    // Ack looks only at registered state, so a same-cycle pop never frees a slot for it.
    fill_ack    = fill_rdy && !ack_q && !fifo_full && !i_rst;
    pop         = !fifo_empty && (occ_q != OCC_FULL);
    head_id     = fifo_id_q[fifo_rd_q];
    free_ok     = free_dval && ((occ_q != '0) || pop);
    // With no live line, a free can only retire the line being allocated this cycle.
    exp_free_id = (occ_q == '0) ? head_id : id_ram_q[rptr_q];

    ack_d      = fill_ack;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    err_d      = err_q;
    wad_d      = pop;
    whiaddr_d  = whiaddr_q;
    wdata_d    = wdata_q;
    wid_d      = wid_q;

    if (fill_ack) begin
      fifo_wr_d = fifo_wr_q + 1'b1;
    end
    if (pop) begin
      fifo_rd_d = fifo_rd_q + 1'b1;
      wptr_d    = wptr_q + 1'b1;
      whiaddr_d = wptr_q;
      wdata_d   = fifo_data_q[fifo_rd_q];
      wid_d     = head_id;
    end
    case ({fill_ack, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (free_ok) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({pop, free_ok})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if ((free_dval && !free_ok) || (free_ok && (i_free_id != exp_free_id))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q      <= 1'b0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      err_q      <= 1'b0;
      wad_q      <= 1'b0;
      whiaddr_q  <= '0;
      wdata_q    <= '0;
      wid_q      <= '0;
    end else begin
      ack_q      <= ack_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      err_q      <= err_d;
      wad_q      <= wad_d;
      whiaddr_q  <= whiaddr_d;
      wdata_q    <= wdata_d;
      wid_q      <= wid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (fill_ack) begin
      fifo_data_q[fifo_wr_q] <= i_fill_data;
      fifo_id_q[fifo_wr_q]   <= i_fill_id;
    end
    if (pop && !i_rst) begin
      id_ram_q[wptr_q] <= head_id;
    end
  end

  assign wad_dval  = wad_q;
  assign o_whiaddr = whiaddr_q;
  assign o_wdata   = wdata_q;
  assign o_wid     = wid_q;
  assign o_occ     = occ_q;
  assign o_err     = err_q;

`ifdef REMAP_FILL_PERF_EN
  logic [31:0] stall_full_q, stall_full_d;
  logic [31:0] stall_fifo_q, stall_fifo_d;

  always_comb begin
    stall_full_d = stall_full_q;
    stall_fifo_d = stall_fifo_q;
    if (!fifo_empty && (occ_q == OCC_FULL) && (stall_full_q != '1)) begin
      stall_full_d = stall_full_q + 1'b1;
    end
    if (fill_rdy && fifo_full && (stall_fifo_q != '1)) begin
      stall_fifo_d = stall_fifo_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_full_q <= '0;
      stall_fifo_q <= '0;
    end else begin
      stall_full_q <= stall_full_d;
      stall_fifo_q <= stall_fifo_d;
    end
  end

  assign o_stall_full = stall_full_q;
  assign o_stall_fifo = stall_fifo_q;
`endif

endmodule
